// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake, ALU operand/result and write-back bundle for alu_issue_ctrl.
// The master side is the issue controller; the slave side is fetch + ALU + observers.
interface alu_issue_ctrl_if #(
  parameter int unsigned DATA_W = 32
);

  // Instruction handshake from fetch
  logic              instr_valid;
  logic [31:0]       instr;
  logic              instr_ready;

  // Operands and function code to the ALU
  logic              alu_i;
  logic [DATA_W-1:0] alu_srca;
  logic [DATA_W-1:0] alu_srcb;
  logic [3:0]        alu_af;

  // Combinational ALU response
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;
  logic              alu_neg;
  logic              alu_ovf;

  // Retirement pulse
  logic              wb_valid;
  logic [4:0]        wb_rt;
  logic [DATA_W-1:0] wb_data;

  modport master (
    input  instr_valid, instr,
    output instr_ready,
    output alu_i, alu_srca, alu_srcb, alu_af,
    input  alu_res, alu_zero, alu_neg, alu_ovf,
    output wb_valid, wb_rt, wb_data
  );

  modport slave (
    output instr_valid, instr,
    input  instr_ready,
    input  alu_i, alu_srca, alu_srcb, alu_af,
    output alu_res, alu_zero, alu_neg, alu_ovf,
    input  wb_valid, wb_rt, wb_data
  );

endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the I-type ALU: accepts MIPS I-type instructions, reads rs
// from a local register file, drives the ALU, and writes the result back to rt.
// Traps on signed overflow (addi/slti) and on opcodes outside the I-type ALU group.
module alu_issue_ctrl #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RF_DEPTH = 32,
  parameter int unsigned COUNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  alu_issue_ctrl_if.master    bus,
  output logic                flag_z,
  output logic                flag_n,
  output logic                trap,
  output logic [1:0]          trap_cause,
  input  logic                trap_clr,
  output logic [COUNT_W-1:0]  retired,
  input  logic [4:0]          dbg_addr,
  output logic [DATA_W-1:0]   dbg_data
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned AF_W   = 4;

  localparam logic [AF_W-1:0] AF_ADDI = 4'b0000;
  localparam logic [AF_W-1:0] AF_SLTI = 4'b0010;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_OVF  = 2'b01;
  localparam logic [1:0] CAUSE_ILL  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WB    = 2'b10,
    TRAP  = 2'b11
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] rf [RF_DEPTH];
  logic [REG_W-1:0]  rt_q;

  // Instruction fields of the word currently offered by fetch
  logic [5:0]        op_c;
  logic [REG_W-1:0]  rs_c;
  logic [REG_W-1:0]  rt_c;
  logic [IMM_W-1:0]  imm_c;
  logic              legal_c;
  logic [AF_W-1:0]   af_c;
  logic [DATA_W-1:0] rs_val_c;
  logic              accept_c;
  logic              ovf_trap_c;

  assign op_c  = bus.instr[31:26];
  assign rs_c  = bus.instr[25:21];
  assign rt_c  = bus.instr[20:16];
  assign imm_c = bus.instr[15:0];

  assign accept_c = bus.instr_valid && bus.instr_ready;

  // Opcode decode: the eight I-type ALU opcodes map onto function codes 0..7
  always_comb begin
    legal_c = 1'b0;
    af_c    = '0;
    case (op_c)
      6'b001000: begin legal_c = 1'b1; af_c = 4'b0000; end // addi
      6'b001001: begin legal_c = 1'b1; af_c = 4'b0001; end // addiu
      6'b001010: begin legal_c = 1'b1; af_c = 4'b0010; end // slti
      6'b001011: begin legal_c = 1'b1; af_c = 4'b0011; end // sltiu
      6'b001100: begin legal_c = 1'b1; af_c = 4'b0100; end // andi
      6'b001101: begin legal_c = 1'b1; af_c = 4'b0101; end // ori
      6'b001110: begin legal_c = 1'b1; af_c = 4'b0110; end // xori
      6'b001111: begin legal_c = 1'b1; af_c = 4'b0111; end // lui
      default:   begin legal_c = 1'b0; af_c = '0;      end
    endcase
  end

  // rs operand read; r0 is hardwired to zero
  always_comb begin
    rs_val_c = '0;
    if (rs_c != '0) begin
      rs_val_c = rf[rs_c];
    end
  end

  // Only the signed ops (addi, slti) turn an ALU overflow into a trap
  assign ovf_trap_c = bus.alu_ovf &&
                      ((bus.alu_af == AF_ADDI) || (bus.alu_af == AF_SLTI));

  // Debug read port, combinational; r0 always reads zero
  always_comb begin
    dbg_data = '0;
    if (dbg_addr != '0) begin
      dbg_data = rf[dbg_addr];
    end
  end

  // Issue FSM with registered outputs; RF write happens on the ISSUE->WB edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      rt_q            <= '0;
      bus.instr_ready <= 1'b0;
      bus.alu_i       <= 1'b0;
      bus.alu_srca    <= '0;
      bus.alu_srcb    <= '0;
      bus.alu_af      <= '0;
      bus.wb_valid    <= 1'b0;
      bus.wb_rt       <= '0;
      bus.wb_data     <= '0;
      flag_z          <= 1'b0;
      flag_n          <= 1'b0;
      trap            <= 1'b0;
      trap_cause      <= CAUSE_NONE;
      retired         <= '0;
      for (int unsigned i = 0; i < RF_DEPTH; i++) begin
        rf[i] <= '0;
      end
    end else begin
      bus.wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            bus.instr_ready <= 1'b0;
            rt_q            <= rt_c;
            if (legal_c) begin
              state        <= ISSUE;
              bus.alu_i    <= 1'b1;
              bus.alu_af   <= af_c;
              bus.alu_srca <= rs_val_c;
              bus.alu_srcb <= DATA_W'(imm_c);
            end else begin
              state      <= TRAP;
              trap       <= 1'b1;
              trap_cause <= CAUSE_ILL;
            end
          end else begin
            bus.instr_ready <= 1'b1;
          end
        end

        ISSUE: begin
          bus.alu_i    <= 1'b0;
          bus.alu_af   <= '0;
          bus.alu_srca <= '0;
          bus.alu_srcb <= '0;
          if (ovf_trap_c) begin
            state      <= TRAP;
            trap       <= 1'b1;
            trap_cause <= CAUSE_OVF;
          end else begin
            state       <= WB;
            bus.wb_valid <= 1'b1;
            bus.wb_rt   <= rt_q;
            bus.wb_data <= bus.alu_res;
            flag_z      <= bus.alu_zero;
            flag_n      <= bus.alu_neg;
            retired     <= retired + COUNT_W'(1);
            if (rt_q != '0) begin
              rf[rt_q] <= bus.alu_res;
            end
          end
        end

        WB: begin
          state           <= IDLE;
          bus.instr_ready <= 1'b1;
        end

        TRAP: begin
          if (trap_clr) begin
            state           <= IDLE;
            trap            <= 1'b0;
            trap_cause      <= CAUSE_NONE;
            bus.instr_ready <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural I-type ALU attached.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        flag_z;
  logic        flag_n;
  logic        trap;
  logic [1:0]  trap_cause;
  logic        trap_clr;
  logic [15:0] retired;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int vectors;
  int miscompares;

  alu_issue_ctrl_if #(.DATA_W(32)) bus ();

  alu_issue_ctrl #(
    .DATA_W  (32),
    .RF_DEPTH(32),
    .COUNT_W (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .trap      (trap),
    .trap_cause(trap_cause),
    .trap_clr  (trap_clr),
    .retired   (retired),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: sign-extends for arithmetic/compare, zero-extends for logic
  logic [31:0] sx;
  logic [31:0] zx;
  logic [31:0] sum;
  always_comb begin
    sx  = {{16{bus.alu_srcb[15]}}, bus.alu_srcb[15:0]};
    zx  = {16'h0000, bus.alu_srcb[15:0]};
    sum = bus.alu_srca + sx;
    bus.alu_res = 32'h0;
    bus.alu_ovf = 1'b0;
    case (bus.alu_af)
      4'd0, 4'd1: begin
        bus.alu_res = sum;
        bus.alu_ovf = (bus.alu_srca[31] == sx[31]) && (sum[31] != bus.alu_srca[31]);
      end
      4'd2: bus.alu_res = ($signed(bus.alu_srca) < $signed(sx)) ? 32'd1 : 32'd0;
      4'd3: bus.alu_res = (bus.alu_srca < sx) ? 32'd1 : 32'd0;
      4'd4: bus.alu_res = bus.alu_srca & zx;
      4'd5: bus.alu_res = bus.alu_srca | zx;
      4'd6: bus.alu_res = bus.alu_srca ^ zx;
      4'd7: bus.alu_res = {bus.alu_srcb[15:0], 16'h0000};
      default: bus.alu_res = 32'h0;
    endcase
    bus.alu_zero = (bus.alu_res == 32'h0);
    bus.alu_neg  = bus.alu_res[31];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic read_rf(input logic [4:0] addr, input string tag, input logic [31:0] exp);
    dbg_addr = addr;
    #1;
    check(tag, dbg_data, exp);
  endtask

  // Offers one instruction at a negedge, returns at the negedge after acceptance
  task automatic send(input logic [31:0] word);
    int waited;
    waited = 0;
    while (bus.instr_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) check("ready_timeout", {31'h0, bus.instr_ready}, 32'h1);
    bus.instr       = word;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr       = $urandom;
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    rst             = 1'b1;
    trap_clr        = 1'b0;
    dbg_addr        = 5'd0;
    bus.instr_valid = 1'b0;
    bus.instr       = 32'h0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ready",   {31'h0, bus.instr_ready}, 32'h0);
    check("rst_alu_i",   {31'h0, bus.alu_i}, 32'h0);
    check("rst_wb",      {31'h0, bus.wb_valid}, 32'h0);
    check("rst_trap",    {30'h0, trap, trap_clr ? 1'b1 : trap}, 32'h0);
    check("rst_cause",   {30'h0, trap_cause}, 32'h0);
    check("rst_retired", {16'h0, retired}, 32'h0);
    rst = 1'b0;
    #1;
    check("ready_before_edge", {31'h0, bus.instr_ready}, 32'h0);
    @(negedge clk);
    check("ready_after_rst", {31'h0, bus.instr_ready}, 32'h1);

    // addi r1,r0,5
    send(32'h20010005);
    check("addi_af",   {28'h0, bus.alu_af}, 32'h0);
    check("addi_srcb", bus.alu_srcb, 32'h00000005);
    check("addi_i",    {31'h0, bus.alu_i}, 32'h1);
    check("addi_busy", {31'h0, bus.instr_ready}, 32'h0);
    @(negedge clk);
    check("addi_wbv",  {31'h0, bus.wb_valid}, 32'h1);
    check("addi_wbrt", {27'h0, bus.wb_rt}, 32'h1);
    check("addi_wbd",  bus.wb_data, 32'h5);
    check("addi_ret",  {16'h0, retired}, 32'h1);
    @(negedge clk);
    check("addi_pulse", {31'h0, bus.wb_valid}, 32'h0);
    check("addi_idle",  {31'h0, bus.instr_ready}, 32'h1);
    read_rf(5'd1, "r1", 32'h5);

    // lui r2,0x8000 then addi r2,r2,0xFFFF overflows
    send(32'h3C028000);
    @(negedge clk);
    check("lui2_n", {31'h0, flag_n}, 32'h1);
    @(negedge clk);
    read_rf(5'd2, "r2_lui", 32'h80000000);
    send(32'h2042FFFF);
    check("ovf_srca", bus.alu_srca, 32'h80000000);
    @(negedge clk);
    check("ovf_trap",  {31'h0, trap}, 32'h1);
    check("ovf_cause", {30'h0, trap_cause}, 32'h1);
    check("ovf_nowb",  {31'h0, bus.wb_valid}, 32'h0);
    check("ovf_ready", {31'h0, bus.instr_ready}, 32'h0);
    check("ovf_ret",   {16'h0, retired}, 32'h2);
    read_rf(5'd2, "r2_kept", 32'h80000000);
    // instr_valid while trapped is ignored
    bus.instr       = 32'h20010001;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    check("trap_hold", {31'h0, trap}, 32'h1);
    check("trap_hold_cause", {30'h0, trap_cause}, 32'h1);
    trap_clr = 1'b1;
    @(negedge clk);
    trap_clr = 1'b0;
    check("clr_trap",  {31'h0, trap}, 32'h0);
    check("clr_cause", {30'h0, trap_cause}, 32'h0);
    check("clr_ready", {31'h0, bus.instr_ready}, 32'h1);
    read_rf(5'd1, "r1_intact", 32'h5);

    // trap_clr outside TRAP has no effect
    trap_clr = 1'b1;
    @(negedge clk);
    trap_clr = 1'b0;
    check("clr_idle_trap",  {31'h0, trap}, 32'h0);
    check("clr_idle_ready", {31'h0, bus.instr_ready}, 32'h1);

    // lui r3,0x1234 then slti r4,r3,-1
    send(32'h3C031234);
    @(negedge clk);
    check("lui3_n", {31'h0, flag_n}, 32'h0);
    check("lui3_z", {31'h0, flag_z}, 32'h0);
    @(negedge clk);
    read_rf(5'd3, "r3", 32'h12340000);
    send(32'h2864FFFF);
    check("slti_af", {28'h0, bus.alu_af}, 32'h2);
    @(negedge clk);
    check("slti_wbd", bus.wb_data, 32'h0);
    check("slti_z",   {31'h0, flag_z}, 32'h1);
    check("slti_ret", {16'h0, retired}, 32'h4);
    @(negedge clk);
    read_rf(5'd4, "r4", 32'h0);

    // Illegal opcode traps with cause 10 and never retires
    send(32'h00000000);
    begin
      int n;
      n = 0;
      while (trap !== 1'b1 && n < 4) begin
        if (bus.wb_valid === 1'b1) check("ill_wb", {31'h0, bus.wb_valid}, 32'h0);
        @(negedge clk);
        n++;
      end
    end
    check("ill_trap",  {31'h0, trap}, 32'h1);
    check("ill_cause", {30'h0, trap_cause}, 32'h2);
    check("ill_ret",   {16'h0, retired}, 32'h4);
    trap_clr = 1'b1;
    @(negedge clk);
    trap_clr = 1'b0;
    check("ill_clr", {31'h0, bus.instr_ready}, 32'h1);

    // addiu r0,r0,7 retires but r0 stays zero
    send(32'h24000007);
    @(negedge clk);
    check("r0_wbv",  {31'h0, bus.wb_valid}, 32'h1);
    check("r0_wbrt", {27'h0, bus.wb_rt}, 32'h0);
    check("r0_wbd",  bus.wb_data, 32'h7);
    check("r0_ret",  {16'h0, retired}, 32'h5);
    @(negedge clk);
    read_rf(5'd0, "r0", 32'h0);

    // ori / xori use zero-extended immediates
    send(32'h3406F0F0);
    check("ori_af", {28'h0, bus.alu_af}, 32'h5);
    repeat (2) @(negedge clk);
    read_rf(5'd6, "r6", 32'h0000F0F0);
    send(32'h38C700FF);
    check("xori_af",   {28'h0, bus.alu_af}, 32'h6);
    check("xori_srca", bus.alu_srca, 32'h0000F0F0);
    repeat (2) @(negedge clk);
    read_rf(5'd7, "r7", 32'h0000F00F);

    // Reset during ISSUE of addi r5,r0,9 abandons it
    send(32'h20050009);
    check("rst_mid_i", {31'h0, bus.alu_i}, 32'h1);
    rst = 1'b1;
    #1;
    check("rstm_alu_i",  {31'h0, bus.alu_i}, 32'h0);
    check("rstm_srcb",   bus.alu_srcb, 32'h0);
    check("rstm_ready",  {31'h0, bus.instr_ready}, 32'h0);
    check("rstm_ret",    {16'h0, retired}, 32'h0);
    check("rstm_flags",  {30'h0, flag_z, flag_n}, 32'h0);
    read_rf(5'd7, "rstm_r7", 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstm_wb",    {31'h0, bus.wb_valid}, 32'h0);
    check("rstm_idle",  {31'h0, bus.instr_ready}, 32'h1);
    read_rf(5'd5, "r5", 32'h0);
    @(negedge clk);
    check("rstm_wb2",   {31'h0, bus.wb_valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
